// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory access sequencer.
// Covers states, selector modes and chip-select decoding.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN,
    S_ERR
  } state_e;

  localparam logic [2:0] MODE_BYP_UP = 3'b000;
  localparam logic [2:0] MODE_BYP_DN = 3'b001;
  localparam logic [2:0] MODE_ECC1   = 3'b010;
  localparam logic [2:0] MODE_ECC2   = 3'b011;

  localparam logic [1:0] CE_NONE = 2'b11;

  function automatic logic mode_legal(
    input logic [2:0] m
  );
    return (m == MODE_BYP_UP) ||
           (m == MODE_BYP_DN) ||
           (m == MODE_ECC1)   ||
           (m == MODE_ECC2);
  endfunction

  // Bit 1 selects the up chip, bit 0 the down chip; ECC modes use both.
  function automatic logic [1:0] mode_ce_n(
    input logic [2:0] m
  );
    logic [1:0] ce;
    ce = CE_NONE;
    unique case (1'b1)
      (m == MODE_BYP_UP): ce = 2'b01;
      (m == MODE_BYP_DN): ce = 2'b10;
      (m == MODE_ECC1):   ce = 2'b00;
      (m == MODE_ECC2):   ce = 2'b00;
      default:            ce = CE_NONE;
    endcase
    return ce;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, response and memory-side bundle of the access sequencer.
// master = requester side, slave = sequencer side.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_mode;
  logic [15:0]       rd_data_in;
  logic [2:0]        ecc_flag;
  logic              err_clr;
  logic [2:0]        ecc_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_ce_n;
  logic              mem_we_n;
  logic              mem_oe_n;
  logic              data_oe;
  logic              rsp_valid;
  logic              rsp_err;
  logic [15:0]       rsp_rdata;
  logic [2:0]        rsp_flag;
  logic [15:0]       err_cnt;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_mode,
    output rd_data_in,
    output ecc_flag,
    output err_clr,
    input  req_ready,
    input  ecc_sel,
    input  mem_addr,
    input  mem_ce_n,
    input  mem_we_n,
    input  mem_oe_n,
    input  data_oe,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_rdata,
    input  rsp_flag,
    input  err_cnt
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_mode,
    input  rd_data_in,
    input  ecc_flag,
    input  err_clr,
    output req_ready,
    output ecc_sel,
    output mem_addr,
    output mem_ce_n,
    output mem_we_n,
    output mem_oe_n,
    output data_oe,
    output rsp_valid,
    output rsp_err,
    output rsp_rdata,
    output rsp_flag,
    output err_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer driving two 16-bit memory chips behind the ECC selector.
// Every output is a flop loaded from the next-state view of the FSM.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus
);

  localparam int MAXC  = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
  localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        mode_q, mode_d;

  logic              ready_q, ready_d;
  logic [1:0]        ce_q, ce_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              doe_q, doe_d;
  logic [2:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              vld_q, vld_d;
  logic              rerr_q, rerr_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [2:0]        flag_q, flag_d;

  logic              capture;
  logic              txn;
  logic              acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          mode_d  = bus.req_mode;
          state_d = mode_legal(bus.req_mode) ? S_SETUP : S_ERR;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYC - 1);
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          capture = !we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (TURN_CYC > 0) begin
          state_d = S_TURN;
          cnt_d   = CNT_W'(TURN_CYC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the state being entered so they appear registered.
  always_comb begin
    txn     = (state_d == S_SETUP) ||
              (state_d == S_ACCESS) ||
              (state_d == S_HOLD);
    acc     = (state_d == S_ACCESS);
    ready_d = (state_d == S_IDLE);
    ce_d    = txn ? mode_ce_n(mode_d) : CE_NONE;
    sel_d   = txn ? mode_d : MODE_BYP_UP;
    doe_d   = txn && we_d;
    we_n_d  = !(acc && we_d);
    oe_n_d  = !(acc && !we_d);
    maddr_d = txn ? addr_d : maddr_q;
    vld_d   = (state_d == S_HOLD) || (state_d == S_ERR);
    rerr_d  = (state_d == S_ERR);
    rdata_d = capture ? bus.rd_data_in : rdata_q;
    flag_d  = capture ? bus.ecc_flag : flag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mode_q  <= MODE_BYP_UP;
      ready_q <= 1'b1;
      ce_q    <= CE_NONE;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      sel_q   <= MODE_BYP_UP;
      maddr_q <= '0;
      vld_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      doe_q   <= doe_d;
      sel_q   <= sel_d;
      maddr_q <= maddr_d;
      vld_q   <= vld_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
      flag_q  <= flag_d;
    end
  end

  sat_counter #(
    .W (16)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (capture && (bus.ecc_flag != 3'b000)),
    .clr_i (bus.err_clr),
    .cnt_o (bus.err_cnt)
  );

  assign bus.req_ready = ready_q;
  assign bus.mem_ce_n  = ce_q;
  assign bus.mem_we_n  = we_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.data_oe   = doe_q;
  assign bus.ecc_sel   = sel_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_flag  = flag_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a response scoreboard.
// Pin timing is checked per cycle; responses are checked by a monitor.
module tb_mem_access_ctrl;

  localparam int WC = 2;
  localparam int TC = 1;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    logic [2:0]  flag;
    logic [15:0] cnt;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad = 0;

  rsp_t sbq[$];
  rsp_t mon_e;

  logic [15:0] m_rdata = '0;
  logic [2:0]  m_flag = '0;
  logic [15:0] m_cnt = '0;

  mem_access_ctrl_if #(.ADDR_W(16)) bus ();

  mem_access_ctrl #(
    .ADDR_W   (16),
    .WAIT_CYC (WC),
    .TURN_CYC (TC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_cen(input logic [2:0] m);
    case (m)
      3'b000:         return 2'b01;
      3'b001:         return 2'b10;
      3'b010, 3'b011: return 2'b00;
      default:        return 2'b11;
    endcase
  endfunction

  // Scoreboard monitor: one pop per completion pulse.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected act=1 exp=0");
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_err", bus.rsp_err, mon_e.err);
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_flag", bus.rsp_flag, mon_e.flag);
        chk("err_cnt", bus.err_cnt, mon_e.cnt);
      end
    end
  end

  // Called at a negedge while the DUT is idle.
  task automatic txn(input logic we, input logic [15:0] addr,
                     input logic [2:0] mode, input logic [15:0] rd,
                     input logic [2:0] fl, input logic clr);
    logic legal;
    int n;
    int ph;
    logic txp;
    logic [9:0] ev;
    logic [9:0] av;
    rsp_t e;
    legal = (mode < 3'd4);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_mode = mode;
    bus.rd_data_in = rd;
    bus.ecc_flag = fl;
    if (legal && !we) begin
      m_rdata = rd;
      m_flag = fl;
      if (clr) m_cnt = '0;
      else if (fl != 3'b000 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.err = !legal;
    e.rdata = m_rdata;
    e.flag = m_flag;
    e.cnt = m_cnt;
    sbq.push_back(e);
    n = legal ? (WC + 3 + TC) : 2;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (!legal) ph = (c == 1) ? 5 : 0;
      else if (c == 1) ph = 1;
      else if (c <= WC + 1) ph = 2;
      else if (c == WC + 2) ph = 3;
      else if (c <= WC + 2 + TC) ph = 4;
      else ph = 0;
      txp = (ph >= 1) && (ph <= 3);
      ev = {txp ? exp_cen(mode) : 2'b11,
            !(ph == 2 && we), !(ph == 2 && !we),
            txp && we, txp ? mode : 3'b000,
            ph == 0, (ph == 3) || (ph == 5)};
      av = {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n,
            bus.data_oe, bus.ecc_sel, bus.req_ready, bus.rsp_valid};
      chk($sformatf("pins_m%0d_c%0d", mode, c), av, ev);
      if (txp) chk("mem_addr", bus.mem_addr, addr);
      if (legal && c == WC + 1) bus.err_clr = clr;
      if (c == WC + 2) bus.err_clr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_mode = '0;
    bus.rd_data_in = '0;
    bus.ecc_flag = '0;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pins",
        {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.data_oe,
         bus.ecc_sel, bus.req_ready, bus.rsp_valid, bus.rsp_err},
        {2'b11, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0});
    chk("rst_data", {bus.mem_addr, bus.rsp_rdata, bus.rsp_flag, bus.err_cnt},
        {16'h0, 16'h0, 3'b000, 16'h0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1'b1);

    txn(1'b1, 16'h0012, 3'b010, 16'h0000, 3'b000, 1'b0);
    txn(1'b0, 16'h0100, 3'b000, 16'hBEEF, 3'b000, 1'b0);
    txn(1'b0, 16'h0200, 3'b011, 16'h1111, 3'b010, 1'b0);
    txn(1'b0, 16'h0201, 3'b011, 16'h2222, 3'b010, 1'b0);
    txn(1'b0, 16'h0202, 3'b011, 16'h3333, 3'b010, 1'b0);
    txn(1'b0, 16'h0203, 3'b011, 16'h4444, 3'b010, 1'b1);
    txn(1'b0, 16'hABCD, 3'b001, 16'h1234, 3'b001, 1'b0);
    txn(1'b1, 16'h0055, 3'b000, 16'h0000, 3'b000, 1'b0);
    txn(1'b0, 16'h0777, 3'b101, 16'hDEAD, 3'b111, 1'b0);
    txn(1'b1, 16'h0888, 3'b111, 16'h0000, 3'b000, 1'b0);

    // Abort a write in its first ACCESS cycle.
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0042;
    bus.req_mode = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_abort_we_n", bus.mem_we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pins", {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.data_oe},
        {2'b11, 1'b1, 1'b1, 1'b0});
    chk("abort_err_cnt", bus.err_cnt, 16'h0);
    m_cnt = '0;
    m_rdata = '0;
    m_flag = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {bus.req_ready, bus.rsp_valid}, {1'b1, 1'b0});

    force dut.u_err_cnt.cnt_q = 16'hFFFE;
    #1 release dut.u_err_cnt.cnt_q;
    m_cnt = 16'hFFFE;
    @(negedge clk);
    txn(1'b0, 16'h0300, 3'b010, 16'h5A5A, 3'b100, 1'b0);
    txn(1'b0, 16'h0301, 3'b010, 16'hA5A5, 3'b100, 1'b0);
    txn(1'b0, 16'h0302, 3'b011, 16'h0F0F, 3'b001, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer sitting downstream of the ECC/bypass selector, between it and the two 16-bit memory chips (up/down). Accepts one processor request at a time, drives chip selects, address and write/output-enable strobes with configurable wait states, holds the selector mode stable for the whole access, registers read data and decoder flag, and keeps a saturating count of flagged reads.

## Interface
- ADDR_W, 16, memory address width
- WAIT_CYC, 2, strobe-active cycles per access (legal ≥1)
- TURN_CYC, 1, bus-turnaround idle cycles after each access (legal ≥0)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_mode  in  3  selector mode: 000 bypass up, 001 bypass down, 010 ECC1, 011 ECC2, others illegal
- rd_data_in  in  16  read data from the selector's processor-side output
- ecc_flag  in  3  decoder flag; nonzero = error detected/corrected
- err_clr  in  1  synchronous clear of err_cnt
- ecc_sel  out  3  mode driven to the selector, held for whole transaction
- mem_addr  out  ADDR_W  address to both chips
- mem_ce_n  out  2  [1] = up chip, [0] = down chip, active low
- mem_we_n  out  1  write strobe, active low
- mem_oe_n  out  1  output enable, active low
- data_oe  out  1  FPGA drives memory data bus
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_err  out  1  qualifies rsp_valid: illegal mode
- rsp_rdata  out  16  registered read data
- rsp_flag  out  3  registered ecc_flag of last read
- err_cnt  out  16  flagged-read count, saturating

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, TURN, ERR.
- IDLE: req_ready=1; on req_valid latch we/addr/mode. Legal mode → SETUP; illegal → ERR.
- SETUP (1 cycle): mem_addr, ecc_sel, mem_ce_n valid; strobes high; data_oe=req_we latched.
- ACCESS (WAIT_CYC cycles): write → mem_we_n=0; read → mem_oe_n=0. Last ACCESS cycle of a read captures rd_data_in→rsp_rdata, ecc_flag→rsp_flag.
- HOLD (1 cycle): strobes high, ce/addr/data_oe still held; rsp_valid=1, rsp_err=0. → TURN if TURN_CYC>0 else IDLE.
- TURN (TURN_CYC cycles): ce_n=11, data_oe=0, → IDLE.
- ERR (1 cycle): no chip selected, no strobes; rsp_valid=1, rsp_err=1; rsp_rdata/rsp_flag unchanged; → IDLE.
- Chip select: 000 → ce_n=01; 001 → 10; 010/011 → 00; outside SETUP..HOLD → 11.
- ecc_sel outside a transaction = 000.
- err_cnt: +1 at read capture when ecc_flag≠0; saturates at 16'hFFFF; err_clr wins over simultaneous increment.
- Request inputs ignored outside IDLE.

## Timing
- Reset values: req_ready=1 after reset release, ce_n=11, we_n=1, oe_n=1, data_oe=0, ecc_sel=000, mem_addr=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_flag=0, err_cnt=0, state IDLE.
- Accept at edge 0 → SETUP cycle 1 → ACCESS cycles 2..WAIT_CYC+1 → rsp_valid in cycle WAIT_CYC+2; next accept possible at edge WAIT_CYC+3+TURN_CYC.
- All outputs registered; no combinational path input→output except none.
- Reset asserted mid-access: strobes, ce_n, data_oe deassert immediately (asynchronously); no rsp_valid issued; err_cnt cleared.
- Back-to-back requests with TURN_CYC=0: HOLD→IDLE→SETUP, one cycle of req_ready between accesses.

## Structure
- Package mem_ctrl_pkg: state enum, mode constants (MODE_BYP_UP, MODE_BYP_DN, MODE_ECC1, MODE_ECC2), function mode→ce_n, function mode_legal.
- Sub-module sat_counter (width parameter, inc, clr, saturating) for err_cnt.
- Wait/turnaround timing: single down-counter in the main FSM.

## Test plan
- Write mode 010, addr 0x0012, WAIT_CYC=2 → ce_n=00 cycles 1–4, we_n=0 cycles 2–3, data_oe=1 cycles 1–4, rsp_valid at cycle 4, ecc_sel=010 throughout.
- Read mode 000, rd_data_in=0xBEEF, ecc_flag=0 → oe_n=0 cycles 2–3, ce_n=01, rsp_rdata=0xBEEF, rsp_flag=000, err_cnt unchanged.
- Read mode 011 with ecc_flag=3'b010 three times, then err_clr together with a fourth flagged read → err_cnt 3, then 0.
- Illegal mode 101 → no strobes, ce_n=11, rsp_valid=rsp_err=1 cycle 1, back in IDLE cycle 2.
- rst_n low during ACCESS of a write → we_n=1, ce_n=11, data_oe=0 same cycle, no rsp_valid, req_ready=1 after release.
- err_cnt preloaded to 0xFFFF via 65535 flagged reads (or force) plus one more → stays 0xFFFF.
